// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// regfile_wb_arbiter: merges pipeline (A) and mul/div FIFO (B) writebacks onto the single
// register-file write port, tracks registers still owed by B, and raises a starvation stall.
module regfile_wb_arbiter #(
  parameter int WIDTH      = 64,
  parameter int ADDR       = 5,
  parameter int BLOCKSIZE  = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             p_clk,
  input  logic             p_rst,
  input  logic             p_a_valid,
  input  logic [ADDR-1:0]  p_a_addr,
  input  logic [WIDTH-1:0] p_a_data,
  input  logic             p_b_valid,
  output logic             p_b_ready,
  input  logic [ADDR-1:0]  p_b_addr,
  input  logic [WIDTH-1:0] p_b_data,
  input  logic             p_issue_valid,
  input  logic [ADDR-1:0]  p_issue_addr,
  input  logic [ADDR-1:0]  p_chk_addr1,
  input  logic [ADDR-1:0]  p_chk_addr2,
  output logic             p_hazard1,
  output logic             p_hazard2,
  output logic             p_stall,
  output logic             p_rf_we,
  output logic [ADDR-1:0]  p_rf_waddr,
  output logic [WIDTH-1:0] p_rf_din
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [ADDR-1:0]      fifo_addr [DEPTH];
  logic [WIDTH-1:0]     fifo_data [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [BLOCKSIZE-1:0] pending;
  logic [BLOCKSIZE-1:0] pending_nxt;
  logic [CW-1:0]        starve_cnt;
  logic [CW-1:0]        starve_nxt;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [ADDR-1:0]      head_addr;
  logic [WIDTH-1:0]     head_data;

  assign empty     = (wr_ptr == rd_ptr);
  // Same slot on a different lap means full; the extra pointer MSB tells the laps apart.
  assign full      = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign p_b_ready = ~full;
  assign push      = p_b_valid & ~full;
  assign pop       = ~p_a_valid & ~empty;
  assign head_addr = fifo_addr[rd_ptr[IW-1:0]];
  assign head_data = fifo_data[rd_ptr[IW-1:0]];

  assign p_hazard1 = pending[p_chk_addr1] & (p_chk_addr1 != '0);
  assign p_hazard2 = pending[p_chk_addr2] & (p_chk_addr2 != '0);

  // A new issue to a register overrides the clear from a retiring older result.
  always_comb begin
    pending_nxt = pending;
    if (pop)
      pending_nxt[head_addr] = 1'b0;
    if (p_issue_valid && (p_issue_addr != '0))
      pending_nxt[p_issue_addr] = 1'b1;
  end

  always_comb begin
    if (empty || pop)
      starve_nxt = '0;
    else if (starve_cnt == CW'(STARVE_MAX))
      starve_nxt = starve_cnt;
    else
      starve_nxt = starve_cnt + CW'(1);
  end

  always_ff @(posedge p_clk) begin
    if (push) begin
      fifo_addr[wr_ptr[IW-1:0]] <= p_b_addr;
      fifo_data[wr_ptr[IW-1:0]] <= p_b_data;
    end
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      starve_cnt <= '0;
      p_stall    <= 1'b0;
      p_rf_we    <= 1'b0;
      p_rf_waddr <= '0;
      p_rf_din   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      pending    <= pending_nxt;
      starve_cnt <= starve_nxt;
      p_stall    <= (starve_nxt == CW'(STARVE_MAX));
      if (p_a_valid) begin
        p_rf_we    <= (p_a_addr != '0);
        p_rf_waddr <= p_a_addr;
        p_rf_din   <= p_a_data;
      end else if (pop) begin
        p_rf_we    <= (head_addr != '0);
        p_rf_waddr <= head_addr;
        p_rf_din   <= head_data;
      end else begin
        p_rf_we    <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued per source at
// issue time and a negedge monitor pops and compares every register-file write.
module tb_regfile_wb_arbiter;
  localparam int WIDTH = 64;
  localparam int ADDR  = 5;

  typedef logic [ADDR+WIDTH-1:0] ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_valid, b_valid, issue_valid;
  logic [ADDR-1:0]  a_addr, b_addr, issue_addr, chk_addr1, chk_addr2;
  logic [WIDTH-1:0] a_data, b_data;
  logic             b_ready, hazard1, hazard2, stall, rf_we;
  logic [ADDR-1:0]  rf_waddr;
  logic [WIDTH-1:0] rf_din;

  ent_t exp_a[$];
  ent_t exp_b[$];
  ent_t mon_got;
  ent_t mon_exp;
  logic a_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter dut (
    .p_clk(clk), .p_rst(rst),
    .p_a_valid(a_valid), .p_a_addr(a_addr), .p_a_data(a_data),
    .p_b_valid(b_valid), .p_b_ready(b_ready), .p_b_addr(b_addr), .p_b_data(b_data),
    .p_issue_valid(issue_valid), .p_issue_addr(issue_addr),
    .p_chk_addr1(chk_addr1), .p_chk_addr2(chk_addr2),
    .p_hazard1(hazard1), .p_hazard2(hazard2), .p_stall(stall),
    .p_rf_we(rf_we), .p_rf_waddr(rf_waddr), .p_rf_din(rf_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) a_prev <= a_valid;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    issue_valid = 1'b0;
  endtask

  // Writes in a cycle after A was valid belong to A; all others drain from the B FIFO.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      mon_got = {rf_waddr, rf_din};
      if (a_prev) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_write: got addr=%0d data=0x%0h, expected no write", rf_waddr, rf_din);
        end else begin
          mon_exp = exp_a.pop_front();
          chkw("a_write", 72'(mon_got), 72'(mon_exp));
        end
      end else begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_write: got addr=%0d data=0x%0h, expected no write", rf_waddr, rf_din);
        end else begin
          mon_exp = exp_b.pop_front();
          chkw("b_write", 72'(mon_got), 72'(mon_exp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int sent;
    int cyc;
    logic [31:0] pat;
    idle();
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_we", rf_we, 1'b0);
    chkw("reset_waddr", 72'(rf_waddr), 72'(0));
    chkw("reset_din", 72'(rf_din), 72'(0));
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_b_ready", b_ready, 1'b1);
    chk1("reset_hazard1", hazard1, 1'b0);
    chk1("reset_hazard2", hazard2, 1'b0);
    tick();
    rst = 1'b0;

    // A write shows up one cycle later
    tick();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h1122334455667788;
    exp_a.push_back({5'd3, 64'h1122334455667788});
    tick();
    idle();
    @(negedge clk);
    chk1("a_lat_we", rf_we, 1'b1);
    chkw("a_lat_waddr", 72'(rf_waddr), 72'(3));
    chkw("a_lat_din", 72'(rf_din), 72'(64'h1122334455667788));

    // Reset mid-stream clears outputs asynchronously and discards B entry and pending bit
    tick();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 64'hDEADBEEF00000009;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 64'h10;
    issue_valid = 1'b1; issue_addr = 5'd4; chk_addr1 = 5'd4;
    tick();
    idle();
    chk1("pre_rst_we", rf_we, 1'b1);
    chk1("pre_rst_hazard", hazard1, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_we", rf_we, 1'b0);
    chkw("mid_rst_waddr", 72'(rf_waddr), 72'(0));
    chkw("mid_rst_din", 72'(rf_din), 72'(0));
    chk1("mid_rst_hazard", hazard1, 1'b0);
    chk1("mid_rst_b_ready", b_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("post_rst_idle_we", rf_we, 1'b0);
    end

    // Scoreboard hazard and B latency of two cycles
    tick();
    issue_valid = 1'b1; issue_addr = 5'd7; chk_addr1 = 5'd7;
    tick();
    issue_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'hABCD;
    exp_b.push_back({5'd7, 64'hABCD});
    @(negedge clk);
    chk1("issue_hazard", hazard1, 1'b1);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    chk1("b_lat_n1_we", rf_we, 1'b0);
    chk1("hazard_held", hazard1, 1'b1);
    tick();
    @(negedge clk);
    chk1("b_lat_n2_we", rf_we, 1'b1);
    chk1("hazard_clear", hazard1, 1'b0);

    // A every cycle fills FIFO and starves it; then drain in order
    tick();
    for (int i = 0; i < 16; i++) begin
      a_valid = (i < 10);
      a_addr  = 5'd16 + 5'(i);
      a_data  = {32'hA5A50000, 32'(i)};
      if (i < 10) exp_a.push_back({5'd16 + 5'(i), 32'hA5A50000, 32'(i)});
      b_valid = (i < 4);
      b_addr  = 5'd11 + 5'(i);
      b_data  = {32'hB0B00000, 32'(i)};
      if (i < 4) exp_b.push_back({5'd11 + 5'(i), 32'hB0B00000, 32'(i)});
      @(negedge clk);
      if (i == 4)  chk1("full_b_ready", b_ready, 1'b0);
      if (i == 8)  chk1("stall_before", stall, 1'b0);
      if (i == 9)  chk1("stall_rise", stall, 1'b1);
      if (i == 10) chk1("stall_hold", stall, 1'b1);
      if (i == 11) begin
        chk1("stall_fall", stall, 1'b0);
        chk1("drain_b_ready", b_ready, 1'b1);
      end
      if (i >= 11 && i <= 14) chk1("drain_consecutive_we", rf_we, 1'b1);
      tick();
    end

    // Register 0 writes from both sources are suppressed; FIFO still drains
    for (int i = 0; i < 12; i++) begin
      a_valid = (i < 4); a_addr = 5'd0; a_data = 64'hFFFF;
      b_valid = (i < 4); b_addr = 5'd0; b_data = 64'(i);
      @(negedge clk);
      chk1("r0_no_we", rf_we, 1'b0);
      if (i == 4) chk1("r0_full", b_ready, 1'b0);
      if (i == 6) chk1("r0_b_ready_back", b_ready, 1'b1);
      tick();
    end

    // Issue and pop of the same register on one edge: set wins
    chk_addr1 = 5'd0; chk_addr2 = 5'd5;
    issue_valid = 1'b1; issue_addr = 5'd5;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 64'h5555;
    exp_b.push_back({5'd5, 64'h5555});
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    chk1("sw_hazard_e1", hazard2, 1'b1);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk1("set_wins_hazard", hazard2, 1'b1);
    chk1("r0_chk_hazard", hazard1, 1'b0);
    tick();
    b_valid = 1'b1; b_addr = 5'd5; b_data = 64'h5556;
    exp_b.push_back({5'd5, 64'h5556});
    @(negedge clk);
    chk1("sw_hazard_e3", hazard2, 1'b1);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    chk1("sw_hazard_e4", hazard2, 1'b1);
    tick();
    @(negedge clk);
    chk1("sw_hazard_cleared", hazard2, 1'b0);

    // 20 B results with interleaved A traffic across pointer wrap
    tick();
    sent = 0;
    cyc  = 0;
    pat  = 32'hB5A36C9D;
    while (sent < 20 && cyc < 200) begin
      a_valid = pat[cyc % 32];
      a_addr  = 5'd20 + 5'(cyc % 8);
      a_data  = {32'hA6A6A6A6, 32'(cyc)};
      if (a_valid) exp_a.push_back({5'd20 + 5'(cyc % 8), 32'hA6A6A6A6, 32'(cyc)});
      b_valid = 1'b1;
      b_addr  = 5'(1 + sent % 31);
      b_data  = {32'hB1B1B1B1, 32'(sent)};
      if (b_ready) begin
        exp_b.push_back({5'(1 + sent % 31), 32'hB1B1B1B1, 32'(sent)});
        sent++;
      end
      cyc++;
      tick();
    end
    idle();
    chkw("b_stream_sent", 72'(sent), 72'(20));
    repeat (20) tick();
    chkw("all_writes_seen", 72'(exp_a.size() + exp_b.size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the dual-read register file between two writeback sources.
  - Source A: the main pipeline (ALU/load). Single-cycle, highest priority, no backpressure.
  - Source B: the long-latency mul/div unit. Valid/ready handshake into a small FIFO.
- Keeps a pending-write scoreboard so decode can detect RAW hazards on registers still owed by source B.
- Raises a starvation stall toward the pipeline when B results wait too long.

Parameters:
- WIDTH, 64, data width of a register.
- ADDR, 5, register address width.
- BLOCKSIZE, 32, number of registers (scoreboard bits).
- DEPTH, 4, source-B FIFO entries (power of 2, >= 2).
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may go unserved before stall is raised.

Ports:
- p_clk  in  1  clock, all state on rising edge.
- p_rst  in  1  asynchronous, active-high reset.
- p_a_valid  in  1  pipeline writeback valid.
- p_a_addr  in  ADDR  pipeline destination register.
- p_a_data  in  WIDTH  pipeline writeback data.
- p_b_valid  in  1  mul/div result valid.
- p_b_ready  out  1  FIFO can accept; equals not-full.
- p_b_addr  in  ADDR  mul/div destination register.
- p_b_data  in  WIDTH  mul/div result data.
- p_issue_valid  in  1  a mul/div op is issued this cycle.
- p_issue_addr  in  ADDR  destination of the issued op.
- p_chk_addr1  in  ADDR  decode source operand 1.
- p_chk_addr2  in  ADDR  decode source operand 2.
- p_hazard1  out  1  chk_addr1 has a pending B write.
- p_hazard2  out  1  chk_addr2 has a pending B write.
- p_stall  out  1  pipeline must hold p_a_valid low.
- p_rf_we  out  1  register file write enable.
- p_rf_waddr  out  ADDR  register file write address.
- p_rf_din  out  WIDTH  register file write data.

Behaviour:
- Reset (async, p_rst high): FIFO empty, scoreboard all 0, starve counter 0.
  - p_rf_we=0, p_rf_waddr=0, p_rf_din=0, p_stall=0.
  - p_b_ready=1, p_hazard1/2=0.
  - Reset mid-operation discards all buffered results and pending bits.
- B accept: handshake when p_b_valid & p_b_ready.
  - Entry {addr,data} is pushed at that edge.
  - When full, p_b_ready=0 even if a pop happens the same cycle (no pass-through).
- Arbitration, evaluated each cycle, result registered onto the rf_* outputs:
  1. If p_a_valid: select A. A is never dropped, even while p_stall=1.
  2. Else if the FIFO is non-empty: pop the head and select it.
  3. Else: p_rf_we=0 next cycle. p_rf_waddr/p_rf_din hold their previous values.
- Latency:
  - A valid in cycle N gives p_rf_we=1 in cycle N+1.
  - B accepted in cycle N, with no A traffic, gives p_rf_we=1 in cycle N+2. There is no bypass of the FIFO.
- Register 0:
  - A selected with addr 0: no write; p_rf_we=0.
  - FIFO head with addr 0: still popped; p_rf_we=0.
  - Issue to addr 0: ignored by the scoreboard.
- Scoreboard:
  - p_issue_valid with a nonzero addr sets pending[addr].
  - The bit clears at the edge where a B entry for that addr is popped.
  - Set and clear of the same addr on the same edge: set wins.
  - p_hazardN = pending[p_chk_addrN] & (p_chk_addrN != 0), combinational.
  - A writes never touch the scoreboard.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_MAX.
  - Resets to 0 on any pop, or when the FIFO is empty.
  - p_stall is registered: it goes high the cycle after the counter reaches STARVE_MAX.
  - p_stall goes low the cycle after a pop.
- FIFO pointers: ADDR-independent, log2(DEPTH)+1 bits; wrap-around is handled by the MSB compare.

Test Plan:
- Reset, then A write (addr 3, data 0x1122334455667788) in cycle 1 -> cycle 2 shows rf_we=1, waddr=3, din=0x1122334455667788. Assert p_rst mid-stream -> all outputs return to 0 immediately.
- Issue addr 7, check chk_addr1=7 -> hazard1=1. B push (7, 0xABCD) with A idle -> rf_we for addr 7 two cycles later. hazard1=0 from the cycle after the pop edge.
- A valid every cycle while 4 B results push -> b_ready=0 after 4 pushes. p_stall=1 in the cycle after 8 unserved cycles. Drop A -> FIFO drains in order, 4 consecutive rf_we. stall low after the first pop.
- A writes addr 0, B pushes addr 0 -> no rf_we is ever asserted. FIFO still empties and b_ready returns to 1.
- Issue addr 5 on the same edge that B entry 5 pops -> pending[5] stays 1 and hazard persists.
- 20 B results with random A interleave -> all written, in push order, with no loss or duplication across pointer wrap.
